// File: rtl/cic_frame_packer.sv
// cic_frame_packer
//
// Purpose:
//   Captures the six 16-bit decimated channel words from the CIC stage on
//   every in_en strobe. Each capture goes out as one fixed 16-byte frame:
//   HDR0, HDR1, seq, ch1 MSB, ch1 LSB, ... ch6 LSB, csum.
//   Bytes leave one at a time over a valid/ready interface. A second sample
//   set can be held in a pending buffer while the current frame drains.
//   If a set arrives while the pending buffer is already full, that set is
//   dropped. A drop sets the sticky overrun flag and increments the
//   saturating drop counter.
//
// Ports:
//   clk                 in   system clock, shared with the CIC stage
//   rst                 in   synchronous active-low reset
//   data_in1..data_in6  in   16-bit channel words, sampled when in_en=1
//   in_en               in   sample strobe, one sample set per high cycle
//   tx_data             out  current frame byte (8'h00 while idle)
//   tx_valid            out  tx_data holds a frame byte
//   tx_ready            in   downstream takes the byte when tx_valid&&tx_ready
//   busy                out  a frame is in flight (same as tx_valid)
//   overrun             out  sticky: at least one sample set was dropped
//   drop_cnt            out  number of dropped sample sets, saturates at 255

module cic_frame_packer #(
    parameter logic [7:0] HDR0 = 8'hA5,
    parameter logic [7:0] HDR1 = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in1,
    input  logic [15:0] data_in2,
    input  logic [15:0] data_in3,
    input  logic [15:0] data_in4,
    input  logic [15:0] data_in5,
    input  logic [15:0] data_in6,
    input  logic        in_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] frameBuf_q [6];
    logic [15:0] frameBuf_d [6];
    logic [15:0] pendBuf_q  [6];
    logic [15:0] pendBuf_d  [6];
    logic        pendFull_q, pendFull_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  dropCnt_q, dropCnt_d;

    logic [15:0] inSet [6];
    logic        accept;
    logic        lastAccept;
    logic [7:0]  csum;

    // Gather the input ports into an array so that buffer loads are a
    // single assignment.
    always_comb begin
        inSet[0] = data_in1;
        inSet[1] = data_in2;
        inSet[2] = data_in3;
        inSet[3] = data_in4;
        inSet[4] = data_in5;
        inSet[5] = data_in6;
    end

    assign accept     = (state_q == SEND) && tx_ready;
    assign lastAccept = accept && (idx_q == 4'd15);

    // The checksum covers seq and the twelve data bytes. The frame buffer
    // and seq do not change while a frame is in flight, so the sum can be
    // computed combinationally from them.
    always_comb begin
        csum = seq_q;
        for (int i = 0; i < 6; i++) begin
            csum = csum + frameBuf_q[i][15:8] + frameBuf_q[i][7:0];
        end
    end

    // State register and datapath storage, with synchronous active-low reset.
    // The buffer contents are also cleared on reset so that tx_data never
    // carries stale data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            seq_q      <= 8'd0;
            pendFull_q <= 1'b0;
            overrun_q  <= 1'b0;
            dropCnt_q  <= 8'd0;
            for (int i = 0; i < 6; i++) begin
                frameBuf_q[i] <= 16'd0;
                pendBuf_q[i]  <= 16'd0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            pendFull_q <= pendFull_d;
            overrun_q  <= overrun_d;
            dropCnt_q  <= dropCnt_d;
            for (int i = 0; i < 6; i++) begin
                frameBuf_q[i] <= frameBuf_d[i];
                pendBuf_q[i]  <= pendBuf_d[i];
            end
        end
    end

    // Next-state logic.
    // When the last byte of a frame is accepted, a pending set has priority
    // over the set arriving in that same cycle. The arriving set then takes
    // the slot the pending set just freed, so nothing is dropped. A set is
    // dropped only when it arrives while the pending buffer is full and no
    // frame boundary occurs in that cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        pendFull_d = pendFull_q;
        overrun_d  = overrun_q;
        dropCnt_d  = dropCnt_q;
        frameBuf_d = frameBuf_q;
        pendBuf_d  = pendBuf_q;

        case (state_q)
            IDLE: begin
                if (in_en) begin
                    frameBuf_d = inSet;
                    idx_d      = 4'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (lastAccept) begin
                    seq_d = seq_q + 8'd1;
                    idx_d = 4'd0;
                    if (pendFull_q) begin
                        frameBuf_d = pendBuf_q;
                        if (in_en) begin
                            pendBuf_d  = inSet;
                            pendFull_d = 1'b1;
                        end else begin
                            pendFull_d = 1'b0;
                        end
                    end else if (in_en) begin
                        frameBuf_d = inSet;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (accept) begin
                        idx_d = idx_q + 4'd1;
                    end
                    if (in_en) begin
                        if (!pendFull_q) begin
                            pendBuf_d  = inSet;
                            pendFull_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                            if (dropCnt_q != 8'hFF) begin
                                dropCnt_d = dropCnt_q + 8'd1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output byte mux. Byte 3+2k is the MSB of channel k+1 and byte 4+2k
    // is its LSB. tx_data is forced to zero when no frame is in flight.
    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                4'd0:    tx_data = HDR0;
                4'd1:    tx_data = HDR1;
                4'd2:    tx_data = seq_q;
                4'd3:    tx_data = frameBuf_q[0][15:8];
                4'd4:    tx_data = frameBuf_q[0][7:0];
                4'd5:    tx_data = frameBuf_q[1][15:8];
                4'd6:    tx_data = frameBuf_q[1][7:0];
                4'd7:    tx_data = frameBuf_q[2][15:8];
                4'd8:    tx_data = frameBuf_q[2][7:0];
                4'd9:    tx_data = frameBuf_q[3][15:8];
                4'd10:   tx_data = frameBuf_q[3][7:0];
                4'd11:   tx_data = frameBuf_q[4][15:8];
                4'd12:   tx_data = frameBuf_q[4][7:0];
                4'd13:   tx_data = frameBuf_q[5][15:8];
                4'd14:   tx_data = frameBuf_q[5][7:0];
                default: tx_data = csum;
            endcase
        end
    end

    assign tx_valid = (state_q == SEND);
    assign busy     = tx_valid;
    assign overrun  = overrun_q;
    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_cic_frame_packer.sv
// Testbench for cic_frame_packer.
// The first part replays a table of hand-computed vectors: a single frame,
// then the same frame under backpressure. The second part drives multi-cycle
// sequences. Those sequences are checked against a byte-queue model that
// builds each expected frame from the captured sample set.

module tb_cic_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in1 = '0, data_in2 = '0, data_in3 = '0;
    logic [15:0] data_in4 = '0, data_in5 = '0, data_in6 = '0;
    logic        in_en = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        overrun;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    // Model state for the sequence tests.
    logic [7:0] expQ [$];
    logic [7:0] seqModel = 8'd0;
    logic       ovModel = 1'b0;
    logic [7:0] dropModel = 8'd0;

    typedef struct {
        logic       inEn;
        logic       rdy;
        logic       expValid;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [$];

    cic_frame_packer #(.HDR0(8'hA5), .HDR1(8'h5A)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_in3 (data_in3),
        .data_in4 (data_in4),
        .data_in5 (data_in5),
        .data_in6 (data_in6),
        .in_en    (in_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .overrun  (overrun),
        .drop_cnt (drop_cnt)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance one cycle, then wait 1 ns so that outputs are sampled well
    // away from the clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveSet(input logic [95:0] set);
        data_in1 = set[95:80];
        data_in2 = set[79:64];
        data_in3 = set[63:48];
        data_in4 = set[47:32];
        data_in5 = set[31:16];
        data_in6 = set[15:0];
    endtask

    // Append the expected 16-byte frame for one captured set.
    task automatic pushFrame(input logic [95:0] set);
        logic [7:0] sum;
        logic [7:0] b;
        expQ.push_back(8'hA5);
        expQ.push_back(8'h5A);
        expQ.push_back(seqModel);
        sum = seqModel;
        for (int k = 0; k < 12; k++) begin
            b = set[95 - 8 * k -: 8];
            expQ.push_back(b);
            sum = sum + b;
        end
        expQ.push_back(sum);
        seqModel = seqModel + 8'd1;
    endtask

    // Drive one cycle of stimulus, compare the outputs for that cycle with
    // the model, then update the model for the clock edge that follows.
    // While a frame drains, the queue holds the unsent part of that frame
    // plus any pending frame. After the accepted byte is popped, more than
    // 16 queued bytes means the pending slot is still occupied, so an
    // arriving set must be dropped.
    task automatic applyStimulus(input logic en, input logic [95:0] set, input logic rdy);
        int sz;
        in_en    = en;
        tx_ready = rdy;
        driveSet(set);
        sz = expQ.size();
        checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, sz > 0});
        checkOutput("busy", {31'd0, busy}, {31'd0, sz > 0});
        checkOutput("tx_data", {24'd0, tx_data}, {24'd0, (sz > 0) ? expQ[0] : 8'h00});
        checkOutput("overrun", {31'd0, overrun}, {31'd0, ovModel});
        checkOutput("drop_cnt", {24'd0, drop_cnt}, {24'd0, dropModel});
        if (rdy && sz > 0) begin
            void'(expQ.pop_front());
        end
        if (en) begin
            if (expQ.size() > 16) begin
                ovModel = 1'b1;
                if (dropModel != 8'hFF) begin
                    dropModel = dropModel + 8'd1;
                end
            end else begin
                pushFrame(set);
            end
        end
        tick();
        in_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() > 0 && n < 200) begin
            applyStimulus(1'b0, 96'd0, 1'b1);
            n++;
        end
        checkOutput("drainTimeout", expQ.size(), 0);
        applyStimulus(1'b0, 96'd0, 1'b1);
    endtask

    task automatic applyReset();
        rst      = 1'b0;
        in_en    = 1'b0;
        tx_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b1;
        expQ.delete();
        seqModel  = 8'd0;
        ovModel   = 1'b0;
        dropModel = 8'd0;
    endtask

    initial begin
        logic [7:0]  f0 [16];
        logic [7:0]  f1 [16];
        logic [95:0] setInc;
        logic [95:0] setFF;
        logic        e;
        int          frames;

        f0 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h15};
        f1 = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h16};
        setInc = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        setFF  = {6{16'hFFFF}};

        // Table: one frame with tx_ready held high, then a second frame
        // (seq 01) that stalls for two cycles before each byte.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        for (int b = 0; b < 16; b++) vecs.push_back('{1'b0, 1'b1, 1'b1, f0[b]});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00});
        for (int b = 0; b < 16; b++) begin
            vecs.push_back('{1'b0, 1'b0, 1'b1, f1[b]});
            vecs.push_back('{1'b0, 1'b0, 1'b1, f1[b]});
            vecs.push_back('{1'b0, 1'b1, 1'b1, f1[b]});
        end
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00});

        $display("[TB] starting cic_frame_packer bench");
        applyReset();

        driveSet(setInc);
        for (int i = 0; i < vecs.size(); i++) begin
            in_en    = vecs[i].inEn;
            tx_ready = vecs[i].rdy;
            checkOutput("vec_valid", {31'd0, tx_valid}, {31'd0, vecs[i].expValid});
            checkOutput("vec_data", {24'd0, tx_data}, {24'd0, vecs[i].expData});
            tick();
        end
        in_en = 1'b0;

        // A second set arrives during byte 5 and goes out back to back.
        $display("[TB] pending and back-to-back");
        applyReset();
        applyStimulus(1'b1, setInc, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 96'd0, 1'b1);
        applyStimulus(1'b1, setFF, 1'b1);
        drain();
        checkOutput("pend_overrun", {31'd0, overrun}, 32'd0);

        // Three sets within one frame: the third set is dropped.
        $display("[TB] overrun");
        applyStimulus(1'b1, {6{16'h1234}}, 1'b1);
        applyStimulus(1'b0, 96'd0, 1'b1);
        applyStimulus(1'b1, {6{16'hBEEF}}, 1'b1);
        applyStimulus(1'b0, 96'd0, 1'b0);
        applyStimulus(1'b1, {6{16'hDEAD}}, 1'b1);
        drain();
        checkOutput("ovr_overrun", {31'd0, overrun}, 32'd1);
        checkOutput("ovr_drop_cnt", {24'd0, drop_cnt}, 32'd1);

        // A set arrives in the same cycle that byte 15 is accepted, with
        // the pending buffer empty.
        $display("[TB] simultaneous boundary");
        applyStimulus(1'b1, {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666}, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 96'd0, 1'b1);
        applyStimulus(1'b1, {16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213, 16'h1415}, 1'b1);
        drain();
        checkOutput("sim_drop_cnt", {24'd0, drop_cnt}, 32'd1);

        // 257 back-to-back frames, so seq wraps from 255 to 00.
        $display("[TB] seq wrap");
        applyReset();
        frames = 0;
        while (frames < 257) begin
            e = (expQ.size() <= 1);
            applyStimulus(e, {6{16'(frames * 7 + 3)}}, 1'b1);
            if (e) frames++;
        end
        drain();

        // Reset in the middle of a frame, then send a fresh frame.
        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, setFF, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 96'd0, 1'b1);
        applyReset();
        applyStimulus(1'b0, 96'd0, 1'b1);
        applyStimulus(1'b1, setInc, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
